// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/compare/move plus a WIDTH-step
// signed shift-add multiply, with optional saturation and registered status flags.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock_in,
   input  logic             reset_in,
   input  logic             enable_in,
   input  logic             in_valid_in,
   output logic             in_ready_out,
   input  logic [7:0]       opcode_in,
   input  logic             saturate_in,
   input  logic [WIDTH-1:0] alu_input1,
   input  logic [WIDTH-1:0] alu_input2,
   output logic             out_valid_out,
   input  logic             out_ready_in,
   output logic [WIDTH-1:0] alu_output,
   output logic             zero_out,
   output logic             negative_out,
   output logic             overflow_out,
   output logic             illegal_out
);

   localparam int unsigned      CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_FIN  = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_SIGN = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_MUL = 8'h02;
   localparam logic [7:0] OP_EQ  = 8'h03;
   localparam logic [7:0] OP_GT  = 8'h04;
   localparam logic [7:0] OP_MOV = 8'h0B;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [2*WIDTH-1:0]   r_acc, r_mcand, w_addend;
   logic [WIDTH-1:0]     r_mplier;
   logic [CW-1:0]        r_cnt;
   logic                 r_sat;
   logic [WIDTH-1:0]     r_result;
   logic                 r_zero, r_neg, r_ovf, r_ill;

   logic                 w_accept, w_is_mul;
   logic [WIDTH-1:0]     w_sum, w_diff, w_res, w_mul_res;
   logic                 w_ovf, w_ill, w_mul_ovf;
   logic [WIDTH:0]       w_mul_hi;

   assign in_ready_out  = enable_in & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready_in));
   assign w_accept      = in_valid_in & in_ready_out;
   assign w_is_mul      = (opcode_in == OP_MUL);
   assign out_valid_out = (r_state == S_DONE);
   assign alu_output    = r_result;
   assign zero_out      = r_zero;
   assign negative_out  = r_neg;
   assign overflow_out  = r_ovf;
   assign illegal_out   = r_ill;

   always_ff @(posedge clock_in) begin
      if (!reset_in) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
         S_MUL:  if (r_cnt == CNT_FIN) w_next = S_DONE;
         S_DONE: begin
            if (out_ready_in) begin
               if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
               else          w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Overflow on add/sub implies the true result has input1's sign, so it picks the clamp.
   always_comb begin
      w_sum  = alu_input1 + alu_input2;
      w_diff = alu_input1 - alu_input2;
      w_res  = '0;
      w_ovf  = 1'b0;
      w_ill  = 1'b0;
      case (opcode_in)
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = (alu_input1[WIDTH-1] == alu_input2[WIDTH-1]) && (w_sum[WIDTH-1] != alu_input1[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_diff;
            w_ovf = (alu_input1[WIDTH-1] != alu_input2[WIDTH-1]) && (w_diff[WIDTH-1] != alu_input1[WIDTH-1]);
         end
         OP_EQ:  w_res = {{(WIDTH-1){1'b0}}, (alu_input1 == alu_input2)};
         OP_GT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) > $signed(alu_input2))};
         OP_MOV: w_res = alu_input1;
         OP_MUL: w_res = '0;
         default: w_ill = 1'b1;
      endcase
      if (w_ovf && saturate_in) w_res = alu_input1[WIDTH-1] ? NEG_MIN : POS_MAX;
   end

   // Multiplier MSB carries weight -2^(WIDTH-1), so the last partial product is subtracted.
   always_comb begin
      w_addend = '0;
      if (r_mplier[0]) w_addend = (r_cnt == CNT_SIGN) ? -r_mcand : r_mcand;
      w_mul_hi  = r_acc[2*WIDTH-1:WIDTH-1];
      w_mul_ovf = (w_mul_hi != '0) && (w_mul_hi != '1);
      w_mul_res = r_acc[WIDTH-1:0];
      if (w_mul_ovf && r_sat) w_mul_res = r_acc[2*WIDTH-1] ? NEG_MIN : POS_MAX;
   end

   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_sat    <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_ovf    <= 1'b0;
         r_ill    <= 1'b0;
      end else if (w_accept) begin
         if (w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{alu_input1[WIDTH-1]}}, alu_input1};
            r_mplier <= alu_input2;
            r_cnt    <= '0;
            r_sat    <= saturate_in;
         end else begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_neg    <= w_res[WIDTH-1];
            r_ovf    <= w_ovf;
            r_ill    <= w_ill;
         end
      end else if (r_state == S_MUL) begin
         if (r_cnt == CNT_FIN) begin
            r_result <= w_mul_res;
            r_zero   <= (w_mul_res == '0);
            r_neg    <= w_mul_res[WIDTH-1];
            r_ovf    <= w_mul_ovf;
            r_ill    <= 1'b0;
         end else begin
            r_acc    <= r_acc + w_addend;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH 4, 8 and 16: directed vectors push expected
// results; per-instance monitors compare whenever out_valid_out is high.
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, ordy, sat;
   logic [7:0]  op;
   logic        v4, v8, v16, r4, r8, r16, ov4, ov8, ov16;
   logic [3:0]  a4, b4, y4;
   logic [7:0]  a8, b8, y8;
   logic [15:0] a16, b16, y16;
   logic        z4, n4, o4, i4, z8, n8, o8, i8, z16, n16, o16, i16;

   alu_seq #(.WIDTH(4)) u_dut4 (
      .clock_in(clk), .reset_in(rst_n), .enable_in(en), .in_valid_in(v4), .in_ready_out(r4),
      .opcode_in(op), .saturate_in(sat), .alu_input1(a4), .alu_input2(b4),
      .out_valid_out(ov4), .out_ready_in(ordy), .alu_output(y4),
      .zero_out(z4), .negative_out(n4), .overflow_out(o4), .illegal_out(i4));

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clock_in(clk), .reset_in(rst_n), .enable_in(en), .in_valid_in(v8), .in_ready_out(r8),
      .opcode_in(op), .saturate_in(sat), .alu_input1(a8), .alu_input2(b8),
      .out_valid_out(ov8), .out_ready_in(ordy), .alu_output(y8),
      .zero_out(z8), .negative_out(n8), .overflow_out(o8), .illegal_out(i8));

   alu_seq #(.WIDTH(16)) u_dut16 (
      .clock_in(clk), .reset_in(rst_n), .enable_in(en), .in_valid_in(v16), .in_ready_out(r16),
      .opcode_in(op), .saturate_in(sat), .alu_input1(a16), .alu_input2(b16),
      .out_valid_out(ov16), .out_ready_in(ordy), .alu_output(y16),
      .zero_out(z16), .negative_out(n16), .overflow_out(o16), .illegal_out(i16));

   typedef struct {
      logic [15:0] res;
      logic        z, n, o, i;
      string       tag;
   } exp_t;

   exp_t q4[$], q8[$], q16[$];
   int   n_vec = 0, n_err = 0, cyc = 0, last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string tag, input logic [19:0] act, input logic [19:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got res=%h zno_i=%b, required res=%h zno_i=%b",
                  tag, act[19:4], act[3:0], exp[19:4], exp[3:0]);
      end
   endfunction

   function automatic void check_int(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", tag, act, exp);
      end
   endfunction

   function automatic logic [15:0] trunc(input int d, input int v);
      logic [31:0] t;
      t = v;
      case (d)
         4:       return {12'h0, t[3:0]};
         8:       return {8'h0, t[7:0]};
         default: return t[15:0];
      endcase
   endfunction

   function automatic logic msb(input int d, input logic [15:0] v);
      case (d)
         4:       return v[3];
         8:       return v[7];
         default: return v[15];
      endcase
   endfunction

   function automatic bit rdy_of(input int d);
      case (d)
         4:       return r4;
         8:       return r8;
         default: return r16;
      endcase
   endfunction

   function automatic bit vld_of(input int d);
      case (d)
         4:       return ov4;
         8:       return ov8;
         default: return ov16;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n && ov4) begin
         if (q4.size() == 0) check("w4_unexpected_valid", {12'h0, y4, z4, n4, o4, i4}, 20'hFFFFF);
         else begin
            check(q4[0].tag, {12'h0, y4, z4, n4, o4, i4}, {q4[0].res, q4[0].z, q4[0].n, q4[0].o, q4[0].i});
            if (ordy) q4.delete(0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov8) begin
         if (q8.size() == 0) check("w8_unexpected_valid", {8'h0, y8, z8, n8, o8, i8}, 20'hFFFFF);
         else begin
            check(q8[0].tag, {8'h0, y8, z8, n8, o8, i8}, {q8[0].res, q8[0].z, q8[0].n, q8[0].o, q8[0].i});
            if (ordy) q8.delete(0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov16) begin
         if (q16.size() == 0) check("w16_unexpected_valid", {y16, z16, n16, o16, i16}, 20'hFFFFF);
         else begin
            check(q16[0].tag, {y16, z16, n16, o16, i16}, {q16[0].res, q16[0].z, q16[0].n, q16[0].o, q16[0].i});
            if (ordy) q16.delete(0);
         end
      end
   end

   task automatic issue(input int d, input logic [7:0] o, input logic s, input int a, input int b,
                        input int er, input logic eo, input logic ei, input bit push, input string tag);
      logic [15:0] ta, tb;
      exp_t        e;
      bit          got;
      ta = trunc(d, a);
      tb = trunc(d, b);
      op = o;
      sat = s;
      case (d)
         4:       begin a4 = ta[3:0]; b4 = tb[3:0]; v4 = 1'b1; end
         8:       begin a8 = ta[7:0]; b8 = tb[7:0]; v8 = 1'b1; end
         default: begin a16 = ta; b16 = tb; v16 = 1'b1; end
      endcase
      e.res = trunc(d, er);
      e.z   = (e.res == 16'h0);
      e.n   = msb(d, e.res);
      e.o   = eo;
      e.i   = ei;
      e.tag = tag;
      got = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rdy_of(d)) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check_int({tag, "_accept"}, 0, 1);
      else if (push) begin
         case (d)
            4:       q4.push_back(e);
            8:       q8.push_back(e);
            default: q16.push_back(e);
         endcase
      end
      @(posedge clk);
      #1;
      v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;
      last_acc = cyc;
   endtask

   task automatic wait_valid(input int d, output int lat, output bit rs);
      lat = 0;
      rs = 1'b0;
      while (!vld_of(d) && lat < 100) begin
         if (rdy_of(d)) rs = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic mul_chk(input int d, input logic s, input int a, input int b, input int er,
                          input logic eo, input string tag);
      int lat;
      bit rs;
      issue(d, 8'h02, s, a, b, er, eo, 1'b0, 1'b1, tag);
      wait_valid(d, lat, rs);
      check_int({tag, "_latency"}, lat, d + 1);
      check_int({tag, "_ready_in_mul"}, int'(rs), 0);
   endtask

   initial begin
      int  first, lat;
      bit  rs, seen;
      rst_n = 1'b0; en = 1'b1; ordy = 1'b1; sat = 1'b0; op = 8'h00;
      v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      @(negedge clk);
      check("reset_w8", {8'h0, y8, z8, n8, o8, i8}, 20'h0);
      check("reset_w16", {y16, z16, n16, o16, i16}, 20'h0);
      check_int("reset_valid", int'({ov4, ov8, ov16}), 0);
      check_int("reset_ready_en1", int'({r4, r8, r16}), 7);
      en = 1'b0;
      #1;
      check_int("ready_en0", int'({r4, r8, r16}), 0);
      @(posedge clk);
      #1;
      en = 1'b1;

      issue(8, 8'h00, 1'b0, 3, 4, 'h07, 1'b0, 1'b0, 1'b1, "add_3_4");
      first = last_acc;
      issue(8, 8'h00, 1'b0, 127, 1, 'h80, 1'b1, 1'b0, 1'b1, "add_127_1");
      issue(8, 8'h00, 1'b0, -128, -1, 'h7F, 1'b1, 1'b0, 1'b1, "add_m128_m1");
      issue(8, 8'h00, 1'b0, -1, 1, 'h00, 1'b0, 1'b0, 1'b1, "add_m1_1");
      issue(8, 8'h00, 1'b0, -50, 20, 'hE2, 1'b0, 1'b0, 1'b1, "add_m50_20");
      issue(8, 8'h00, 1'b0, 100, 100, 'hC8, 1'b1, 1'b0, 1'b1, "add_100_100");
      issue(8, 8'h01, 1'b0, 5, 7, 'hFE, 1'b0, 1'b0, 1'b1, "sub_5_7");
      issue(8, 8'h01, 1'b0, -128, 1, 'h7F, 1'b1, 1'b0, 1'b1, "sub_m128_1");
      issue(8, 8'h01, 1'b0, 127, -1, 'h80, 1'b1, 1'b0, 1'b1, "sub_127_m1");
      issue(8, 8'h01, 1'b0, 0, -128, 'h80, 1'b1, 1'b0, 1'b1, "sub_0_m128");
      issue(8, 8'h01, 1'b0, 100, 100, 'h00, 1'b0, 1'b0, 1'b1, "sub_100_100");
      issue(8, 8'h03, 1'b0, 5, 5, 'h01, 1'b0, 1'b0, 1'b1, "eq_5_5");
      issue(8, 8'h03, 1'b0, 5, -5, 'h00, 1'b0, 1'b0, 1'b1, "eq_5_m5");
      issue(8, 8'h04, 1'b0, 3, -3, 'h01, 1'b0, 1'b0, 1'b1, "gt_3_m3");
      issue(8, 8'h04, 1'b0, -3, 3, 'h00, 1'b0, 1'b0, 1'b1, "gt_m3_3");
      issue(8, 8'h04, 1'b0, -128, 127, 'h00, 1'b0, 1'b0, 1'b1, "gt_m128_127");
      issue(8, 8'h04, 1'b0, 127, -128, 'h01, 1'b0, 1'b0, 1'b1, "gt_127_m128");
      issue(8, 8'h04, 1'b0, 4, 4, 'h00, 1'b0, 1'b0, 1'b1, "gt_4_4");
      issue(8, 8'h0B, 1'b0, -100, 55, 'h9C, 1'b0, 1'b0, 1'b1, "mov_m100");
      issue(8, 8'h0B, 1'b0, 0, 9, 'h00, 1'b0, 1'b0, 1'b1, "mov_0");
      check_int("throughput_20_ops", last_acc - first, 19);

      issue(8, 8'h00, 1'b1, 100, 100, 'h7F, 1'b1, 1'b0, 1'b1, "sat_add_100_100");
      issue(8, 8'h01, 1'b1, -128, 1, 'h80, 1'b1, 1'b0, 1'b1, "sat_sub_m128_1");
      issue(8, 8'h00, 1'b1, -100, -100, 'h80, 1'b1, 1'b0, 1'b1, "sat_add_m100_m100");
      issue(8, 8'h00, 1'b1, 3, 4, 'h07, 1'b0, 1'b0, 1'b1, "sat_add_3_4");

      issue(8, 8'h02, 1'b0, -7, 9, 'hC1, 1'b0, 1'b0, 1'b1, "mul_m7_9");
      a8 = 8'h55; b8 = 8'h33;
      wait_valid(8, lat, rs);
      check_int("mul_m7_9_latency", lat, 9);
      check_int("mul_m7_9_ready_in_mul", int'(rs), 0);
      mul_chk(8, 1'b0, 16, 16, 'h00, 1'b1, "mul_16_16");
      mul_chk(8, 1'b1, 16, 16, 'h7F, 1'b1, "sat_mul_16_16");
      mul_chk(8, 1'b1, -128, -1, 'h7F, 1'b1, "sat_mul_m128_m1");
      mul_chk(8, 1'b0, -128, -1, 'h80, 1'b1, "mul_m128_m1");
      mul_chk(8, 1'b0, -16, 8, 'h80, 1'b0, "mul_m16_8");
      mul_chk(8, 1'b0, 127, 127, 'h01, 1'b1, "mul_127_127");
      mul_chk(8, 1'b1, 127, 127, 'h7F, 1'b1, "sat_mul_127_127");
      mul_chk(8, 1'b0, -5, -5, 'h19, 1'b0, "mul_m5_m5");

      issue(8, 8'h02, 1'b1, 12, -11, 'h80, 1'b1, 1'b0, 1'b1, "sat_mul_12_m11_endrop");
      en = 1'b0;
      wait_valid(8, lat, rs);
      check_int("mul_endrop_latency", lat, 9);
      en = 1'b1;

      repeat (2) begin @(posedge clk); #1; end
      ordy = 1'b0;
      issue(8, 8'h00, 1'b0, 3, 4, 'h07, 1'b0, 1'b0, 1'b1, "bp_add_3_4");
      op = 8'h01; a8 = 8'd20; b8 = 8'd5; v8 = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (r8) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      check_int("bp_ready_while_held", int'(seen), 0);
      ordy = 1'b1;
      @(negedge clk);
      check_int("bp_ready_on_release", int'(r8), 1);
      q8.push_back('{res: 16'h000F, z: 1'b0, n: 1'b0, o: 1'b0, i: 1'b0, tag: "bp_sub_20_5"});
      @(posedge clk);
      #1;
      v8 = 1'b0;
      check_int("bp_no_bubble", int'(ov8), 1);

      issue(8, 8'h02, 1'b0, 5, 5, 'h19, 1'b0, 1'b0, 1'b0, "rst_mul_5_5");
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_mid_mul_outputs", {8'h0, y8, z8, n8, o8, i8}, 20'h0);
      check_int("rst_mid_mul_valid_ready", int'({ov8, r8}), 1);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (ov8) seen = 1'b1;
      end
      check_int("rst_mid_mul_no_output", int'(seen), 0);
      @(posedge clk);
      #1;

      issue(8, 8'h05, 1'b0, 3, 4, 'h00, 1'b0, 1'b1, 1'b1, "illegal_05");
      check_int("illegal_latency_1", int'(ov8), 1);

      issue(4, 8'h00, 1'b0, 3, 4, 'h7, 1'b0, 1'b0, 1'b1, "w4_add_3_4");
      issue(4, 8'h00, 1'b0, 4, 4, 'h8, 1'b1, 1'b0, 1'b1, "w4_add_4_4");
      issue(4, 8'h00, 1'b1, 4, 4, 'h7, 1'b1, 1'b0, 1'b1, "w4_sat_add_4_4");
      issue(4, 8'h00, 1'b1, -8, -1, 'h8, 1'b1, 1'b0, 1'b1, "w4_sat_add_m8_m1");
      issue(4, 8'h01, 1'b0, -8, 1, 'h7, 1'b1, 1'b0, 1'b1, "w4_sub_m8_1");
      mul_chk(4, 1'b0, -3, 2, 'hA, 1'b0, "w4_mul_m3_2");
      mul_chk(4, 1'b0, 3, 3, 'h9, 1'b1, "w4_mul_3_3");
      mul_chk(4, 1'b1, 3, 3, 'h7, 1'b1, "w4_sat_mul_3_3");
      mul_chk(4, 1'b1, -8, -1, 'h7, 1'b1, "w4_sat_mul_m8_m1");
      mul_chk(4, 1'b0, -2, -4, 'h8, 1'b1, "w4_mul_m2_m4");

      issue(16, 8'h00, 1'b0, 30000, 30000, 'hEA60, 1'b1, 1'b0, 1'b1, "w16_add_30000");
      issue(16, 8'h00, 1'b1, 30000, 30000, 'h7FFF, 1'b1, 1'b0, 1'b1, "w16_sat_add_30000");
      issue(16, 8'h00, 1'b0, 1000, -3000, 'hF830, 1'b0, 1'b0, 1'b1, "w16_add_1000_m3000");
      mul_chk(16, 1'b0, 300, -200, 'h15A0, 1'b1, "w16_mul_300_m200");
      mul_chk(16, 1'b0, 181, 181, 'h7FF9, 1'b0, "w16_mul_181_181");
      mul_chk(16, 1'b0, -256, 128, 'h8000, 1'b0, "w16_mul_m256_128");
      mul_chk(16, 1'b1, 256, 128, 'h7FFF, 1'b1, "w16_sat_mul_256_128");

      for (int k = 0; k < 50 && (q4.size() + q8.size() + q16.size()) != 0; k++) @(posedge clk);
      check_int("queues_drained", q4.size() + q8.size() + q16.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational `alu`. It executes the same opcode set at configurable `WIDTH`, with a registered result and an optional saturating mode. Multiplication runs as a multi-cycle signed shift-add sequence. Status flags are added. The block sits between the CPU register file (operand/opcode source) and the writeback stage (result sink), with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 8, operand/result width in bits (≥ 4), two's-complement signed
- `clock_in`  in  1  clock, all state on rising edge
- `reset_in`  in  1  synchronous, active-low reset
- `enable_in`  in  1  when low, no new operation is accepted; an in-flight operation still completes
- `in_valid_in`  in  1  operand/opcode valid
- `in_ready_out`  out  1  block can accept an operation this cycle
- `opcode_in`  in  8  0x00 add, 0x01 sub, 0x02 mul, 0x03 eq, 0x04 gt, 0x0B move; all others illegal
- `saturate_in`  in  1  sampled with operands; 1 = clamp add/sub/mul results on overflow
- `alu_input1`, `alu_input2`  in  WIDTH  signed operands
- `out_valid_out`  out  1  result valid
- `out_ready_in`  in  1  sink accepts the result
- `alu_output`  out  WIDTH  result
- `zero_out`, `negative_out`  out  1  result == 0; result MSB
- `overflow_out`  out  1  signed overflow occurred (before any clamp)
- `illegal_out`  out  1  opcode was illegal

## Operation
- Accept occurs on an edge where `in_valid_in & in_ready_out & enable_in`. Operands, opcode and `saturate_in` are captured.
- States: IDLE, MUL, DONE.
  - IDLE: accept non-mul → DONE; accept mul → MUL.
  - MUL: one shift-add step per cycle for `WIDTH` cycles, then → DONE.
  - DONE: hold result. `out_valid_out`=1. On `out_ready_in`=1: → IDLE, or directly to DONE/MUL if a new op is accepted the same edge.
- `in_ready_out` = `enable_in & (IDLE | (DONE & out_ready_in))`. Back-to-back single-cycle ops therefore sustain one result per cycle.
- Arithmetic:
  - add/sub: modulo 2^WIDTH.
  - overflow: operand signs equal (add) or differ (sub), and the result sign differs from input1.
  - mul: full 2·WIDTH signed product. Output is the low WIDTH bits. Overflow if the product is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Saturate: on overflow, output +max (0x7F at W=8) if the true result is positive, −min (0x80) if negative. `overflow_out` is still 1.
- eq / gt: signed compare; output 1 or 0 zero-extended. Overflow is 0.
- move: output = `alu_input1`. Overflow is 0.
- Illegal opcode: output 0, `illegal_out`=1, `zero_out`=1, other flags 0. Single-cycle latency.
- Flags are computed from the final (post-clamp) output, except `overflow_out`. All flags are registered with `alu_output` and held stable while `out_valid_out`=1 and `out_ready_in`=0.

## Timing
- Reset (`reset_in`=0 at an edge): state IDLE, `alu_output`=0, all flags 0, `out_valid_out`=0. `in_ready_out` follows `enable_in` from the first cycle after reset. Reset mid-MUL or mid-DONE discards the operation with no output.
- Latency, accept edge → `out_valid_out` high:
  - non-mul ops: 1 cycle.
  - mul: `WIDTH`+1 cycles.
- Outputs are stable from `out_valid_out` rise until the handshake edge.
- During MUL, `in_ready_out`=0 regardless of `enable_in`.
- Dropping `enable_in` during MUL or DONE does not abort; the result is still delivered.
- Simultaneous output handshake and input accept in DONE: the old result retires and the new op loads on the same edge. For a non-mul new op there is no bubble.
- Operand changes after the accept edge have no effect on the in-flight result.

## Test plan
- Exhaustive add/sub/eq/gt/move sweep, W=8, inputs −128..127, `saturate_in`=0, `out_ready_in`=1 → each result matches the modulo/compare model 1 cycle after accept; flags correct; throughput is 1 op per cycle.
- Overflow and saturation, W=8:
  - 100+100, sat=0 → 0x C8 (−56), overflow=1, negative=1.
  - 100+100, sat=1 → 0x7F, overflow=1.
  - −128−1, sat=1 → 0x80, overflow=1.
- Multiply, W=8:
  - −7×9 → 0xC1 (−63), valid exactly 9 cycles after accept, `in_ready_out` low for cycles 1..8.
  - 16×16, sat=0 → 0x00, overflow=1, zero=1.
  - 16×16, sat=1 → 0x7F.
  - −128×−1, sat=1 → 0x7F.
- Backpressure: hold `out_ready_in`=0 for 5 cycles after add 3+4 → output stays 7, `in_ready_out`=0. A new op presented meanwhile is accepted only on the edge where `out_ready_in` rises.
- Illegal opcode 0x05 with 3,4 → output 0, illegal=1, zero=1. Reset (`reset_in`=0) asserted in the 4th cycle of a multiply → next cycle all outputs 0, `out_valid_out` never rises for that op.
- Parametrisation: re-run the add and mul checks at W=4 and W=16, e.g. W=16 300×−200 → 0x15A0 (−60000 mod 2^16), overflow=1, latency 17 cycles.
